// File: rtl/fp_cvt_pkg.sv
// Shared types and constants for the IEEE-754 single <-> int32 converter.
// Exponent limits and the float special-value encodings live here.
package fp_cvt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PACK  = 2'd2
    } state_t;

    typedef enum logic {
        CVT_W_TO_S = 1'b0,
        CVT_S_TO_W = 1'b1
    } op_t;

    localparam logic [7:0]  EXP_BIAS       = 8'd127;
    localparam logic [7:0]  EXP_INT_TOP    = 8'd158;
    localparam logic [7:0]  FP_EXP_SPECIAL = 8'hFF;
    localparam logic [31:0] FP_POS_INF     = 32'h7F80_0000;
    localparam logic [31:0] FP_INT_MIN_S   = 32'hCF00_0000;
    localparam logic [31:0] INT_MIN_W      = 32'h8000_0000;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == FP_EXP_SPECIAL) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (f[30:0] == FP_POS_INF[30:0]);
    endfunction

endpackage

// File: rtl/fp_int_converter.sv
// Iterative IEEE-754 single <-> int32 converter (cvt.s.w / trunc.w.s), one shift per cycle.
// Truncates toward zero; start/done handshake with busy held across the operation.
module fp_int_converter
    import fp_cvt_pkg::*;
#(
    parameter logic [31:0] INVALID_RESULT = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        inexact
);

    state_t      state_r, next_state_s;
    op_t         op_r;
    logic        sign_r;
    logic [31:0] mag_r;
    logic [7:0]  exp_r;
    logic [4:0]  cnt_r;
    logic        special_r;
    logic        inv_acc_r;
    logic        inx_acc_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;
    logic        invalid_r;
    logic        inexact_r;

    logic        ld_sign_s;
    logic [31:0] ld_mag_s;
    logic [7:0]  ld_exp_s;
    logic [4:0]  ld_cnt_s;
    logic        ld_special_s;
    logic        ld_inv_s;
    logic        ld_inx_s;
    logic [7:0]  op_exp_s;
    logic        shift_more_s;
    logic [31:0] pack_res_s;
    logic        pack_inv_s;
    logic        pack_inx_s;

    assign op_exp_s = operand[30:23];

    // Decode the incoming operand into datapath load values and special-case bypasses
    always_comb begin
        ld_sign_s    = operand[31];
        ld_mag_s     = 32'd0;
        ld_exp_s     = 8'd0;
        ld_cnt_s     = 5'd0;
        ld_special_s = 1'b0;
        ld_inv_s     = 1'b0;
        ld_inx_s     = 1'b0;
        if (op_t'(op) == CVT_W_TO_S) begin
            if (operand == 32'd0) begin
                ld_special_s = 1'b1;
            end else begin
                ld_mag_s = operand[31] ? (32'd0 - operand) : operand;
                ld_exp_s = EXP_INT_TOP;
            end
        end else begin
            if (operand == FP_INT_MIN_S) begin
                ld_special_s = 1'b1;
                ld_mag_s     = INT_MIN_W;
            end else if (is_nan(operand) || is_inf(operand) || (op_exp_s >= EXP_INT_TOP)) begin
                ld_special_s = 1'b1;
                ld_mag_s     = INVALID_RESULT;
                ld_inv_s     = 1'b1;
            end else if (op_exp_s < EXP_BIAS) begin
                ld_special_s = 1'b1;
                ld_inx_s     = (operand[30:0] != 31'd0);
            end else begin
                ld_mag_s = {1'b1, operand[22:0], 8'd0};
                ld_cnt_s = 5'(EXP_INT_TOP - op_exp_s);
            end
        end
    end

    // int->float keeps shifting until the leading one reaches bit 31, so the shifter finds the LZC
    always_comb begin
        if (special_r) begin
            shift_more_s = 1'b0;
        end else if (op_r == CVT_S_TO_W) begin
            shift_more_s = (cnt_r != 5'd0);
        end else begin
            shift_more_s = ~mag_r[31];
        end
    end

    // Final result and flags formed from the shifted datapath
    always_comb begin
        pack_res_s = 32'd0;
        pack_inv_s = 1'b0;
        pack_inx_s = 1'b0;
        if (special_r) begin
            pack_res_s = mag_r;
            pack_inv_s = inv_acc_r;
            pack_inx_s = inx_acc_r;
        end else if (op_r == CVT_W_TO_S) begin
            pack_res_s = {sign_r, exp_r, mag_r[30:8]};
            pack_inx_s = |mag_r[7:0];
        end else begin
            pack_res_s = sign_r ? (32'd0 - mag_r) : mag_r;
            pack_inx_s = inx_acc_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (start) next_state_s = SHIFT; else next_state_s = IDLE;
            SHIFT:   if (!shift_more_s) next_state_s = PACK; else next_state_s = SHIFT;
            PACK:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath, shifter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r      <= CVT_W_TO_S;
            sign_r    <= 1'b0;
            mag_r     <= 32'd0;
            exp_r     <= 8'd0;
            cnt_r     <= 5'd0;
            special_r <= 1'b0;
            inv_acc_r <= 1'b0;
            inx_acc_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= 32'd0;
            invalid_r <= 1'b0;
            inexact_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r      <= op_t'(op);
                        sign_r    <= ld_sign_s;
                        mag_r     <= ld_mag_s;
                        exp_r     <= ld_exp_s;
                        cnt_r     <= ld_cnt_s;
                        special_r <= ld_special_s;
                        inv_acc_r <= ld_inv_s;
                        inx_acc_r <= ld_inx_s;
                        busy_r    <= 1'b1;
                        result_r  <= 32'd0;
                        invalid_r <= 1'b0;
                        inexact_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (shift_more_s) begin
                        if (op_r == CVT_S_TO_W) begin
                            inx_acc_r <= inx_acc_r | mag_r[0];
                            mag_r     <= {1'b0, mag_r[31:1]};
                            cnt_r     <= cnt_r - 5'd1;
                        end else begin
                            mag_r <= {mag_r[30:0], 1'b0};
                            exp_r <= exp_r - 8'd1;
                        end
                    end
                end
                PACK: begin
                    result_r  <= pack_res_s;
                    invalid_r <= pack_inv_s;
                    inexact_r <= pack_inx_s;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign invalid = invalid_r;
    assign inexact = inexact_r;

endmodule

// File: tb/tb_fp_int_converter.sv
// Self-checking bench: directed and random conversions against an arithmetic reference model,
// plus handshake and mid-operation reset checks.
module tb_fp_int_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        invalid;
    logic        inexact;

    int n_checks = 0;
    int n_fail   = 0;

    fp_int_converter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .operand (operand),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .invalid (invalid),
        .inexact (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: value semantics with plain integer arithmetic, truncation toward zero
    task automatic model(input logic o, input logic [31:0] x,
                         output logic [31:0] res, output logic inv, output logic inx, output int lat);
        longint m, q, v;
        int p, e, sh;
        res = 32'd0; inv = 1'b0; inx = 1'b0; lat = 2;
        if (o == 1'b0) begin
            if (x != 32'd0) begin
                m = x[31] ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
                p = 0;
                for (int i = 0; i < 32; i++) if (m >= (64'd1 << i)) p = i;
                if (p >= 23) begin
                    q   = m >> (p - 23);
                    inx = ((m % (64'd1 << (p - 23))) != 0);
                end else begin
                    q = m << (23 - p);
                end
                res = {x[31], 8'(127 + p), q[22:0]};
                lat = 2 + 31 - p;
            end
        end else begin
            e = int'(x[30:23]);
            if (x == 32'hCF00_0000) begin
                res = 32'h8000_0000;
            end else if (e >= 158) begin
                res = 32'h7FFF_FFFF; inv = 1'b1;
            end else if (e < 127) begin
                inx = (x[30:0] != 31'd0);
            end else begin
                v  = 64'h80_0000 + longint'(x[22:0]);
                sh = e - 150;
                if (sh >= 0) begin
                    v = v << sh;
                end else begin
                    inx = ((v % (64'd1 << (-sh))) != 0);
                    v   = v >> (-sh);
                end
                res = x[31] ? (32'd0 - v[31:0]) : v[31:0];
                lat = 2 + 158 - e;
            end
        end
    endtask

    task automatic run_conv(input logic o, input logic [31:0] x, input string tag);
        logic [31:0] er;
        logic        ei, ex;
        int          el, m;
        bit          seen;
        model(o, x, er, ei, ex, el);
        @(negedge clk);
        start = 1'b1; op = o; operand = x;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " cleared"}, {result[31:2], invalid, inexact}, 32'd0);
        m = 0; seen = 1'b0;
        while (!seen && m < 40) begin
            @(posedge clk); #1;
            m++;
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " latency"}, 32'(m), 32'(el));
            check({tag, " result"}, result, er);
            check({tag, " flags"}, {30'd0, invalid, inexact}, {30'd0, ei, ex});
            check({tag, " busy_off"}, 32'(busy), 32'd0);
            @(posedge clk); #1;
            check({tag, " done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] x, first_res;
        int dc;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; operand = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", {busy, done, invalid, inexact}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_conv(1'b0, 32'h0000_0001, "w2s one");
        run_conv(1'b0, 32'h8000_0000, "w2s intmin");
        run_conv(1'b0, 32'h0100_0001, "w2s 2^24+1");
        run_conv(1'b0, 32'h0000_0000, "w2s zero");
        run_conv(1'b0, 32'hFFFF_FFFF, "w2s minus1");
        run_conv(1'b1, 32'hC0E0_0000, "s2w -7");
        run_conv(1'b1, 32'h3FC0_0000, "s2w 1.5");
        run_conv(1'b1, 32'h7FC0_0000, "s2w nan");
        run_conv(1'b1, 32'h4F00_0000, "s2w 2^31");
        run_conv(1'b1, 32'hCF00_0000, "s2w -2^31");
        run_conv(1'b1, 32'hFF80_0000, "s2w -inf");
        run_conv(1'b1, 32'h3F00_0000, "s2w 0.5");
        run_conv(1'b1, 32'h0000_0000, "s2w zero");
        run_conv(1'b1, 32'h8000_0001, "s2w -denorm");
        run_conv(1'b1, 32'h4EFF_FFFF, "s2w max");
        run_conv(1'b1, 32'h3F80_0000, "s2w one");

        for (int i = 0; i < 120; i++) begin
            x = $urandom;
            x = x >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = 32'd0 - x;
            run_conv(1'b0, x, "w2s rand");
        end
        for (int i = 0; i < 120; i++) begin
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       x[30:23] = 8'hFF;
                1:       x[30:23] = 8'h00;
                default: x[30:23] = 8'($urandom_range(120, 165));
            endcase
            run_conv(1'b1, x, "s2w rand");
        end

        // Second start while busy must be ignored
        @(negedge clk); start = 1'b1; op = 1'b0; operand = 32'h0000_0001;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; op = 1'b1; operand = 32'h4000_0000;
        @(negedge clk); start = 1'b0;
        dc = 0; first_res = 32'd0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) begin dc++; first_res = result; end
        end
        check("ignore dones", 32'(dc), 32'd1);
        check("ignore result", first_res, 32'h3F80_0000);

        // Reset in the middle of shifting
        @(negedge clk); start = 1'b1; op = 1'b0; operand = 32'h0000_0001;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst outs", {busy, done, invalid, inexact}, 32'd0);
        check("midrst result", result, 32'd0);
        @(negedge clk); start = 1'b1; op = 1'b0; operand = 32'h0000_0005;
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1; start = 1'b0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) dc++;
        end
        check("midrst no done", 32'(dc), 32'd0);
        run_conv(1'b1, 32'hC0E0_0000, "after rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
